// File: rtl/sm83_alu_ctrl_pkg.sv
// Shared types for the SM83 ALU sequencer: opcodes, FSM states, flag layout
// and the flag-source selectors produced by the opcode decoder.
package sm83_alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_ADC = 3'd1,
    OP_SUB = 3'd2,
    OP_SBC = 3'd3,
    OP_AND = 3'd4,
    OP_XOR = 3'd5,
    OP_OR  = 3'd6,
    OP_CP  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_LOW,
    ST_HIGH,
    ST_RESULT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } flags_t;

  typedef struct packed {
    logic r;
    logic s;
    logic v;
  } rsv_t;

  typedef enum logic [1:0] {
    FSEL_CARRY,
    FSEL_INV,
    FSEL_ONE,
    FSEL_ZERO
  } fsel_e;

  function automatic logic flag_pick(input fsel_e sel, input logic carry);
    case (sel)
      FSEL_CARRY: flag_pick = carry;
      FSEL_INV:   flag_pick = ~carry;
      FSEL_ONE:   flag_pick = 1'b1;
      default:    flag_pick = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sm83_alu_ctrl_if.sv
// Host and ALU-side signal bundle of the SM83 ALU sequencer.
interface sm83_alu_ctrl_if #(
  parameter int unsigned ALU_WIDTH = 4
);
  localparam int unsigned DW = 2 * ALU_WIDTH;

  logic          start;
  logic [2:0]    op;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic          cf_in;
  logic [DW-1:0] alu_din;
  logic          load_a;
  logic          load_b;
  logic          shift_oe;
  logic          result_oe;
  logic          op_low;
  logic          op_b_high;
  logic          negate;
  logic          carry_in;
  logic          no_carry_out;
  logic          force_carry;
  logic          ignore_carry;
  logic          alu_carry;
  logic          alu_zero;
  logic          busy;
  logic          result_we;
  logic          done;
  logic          flag_z;
  logic          flag_n;
  logic          flag_h;
  logic          flag_c;

  modport master (
    output start, op, a_in, b_in, cf_in, alu_carry, alu_zero,
    input  alu_din, load_a, load_b, shift_oe, result_oe, op_low, op_b_high,
           negate, carry_in, no_carry_out, force_carry, ignore_carry,
           busy, result_we, done, flag_z, flag_n, flag_h, flag_c
  );

  modport slave (
    input  start, op, a_in, b_in, cf_in, alu_carry, alu_zero,
    output alu_din, load_a, load_b, shift_oe, result_oe, op_low, op_b_high,
           negate, carry_in, no_carry_out, force_carry, ignore_carry,
           busy, result_we, done, flag_z, flag_n, flag_h, flag_c
  );
endinterface

// File: rtl/sm83_alu_op_decode.sv
// Pure opcode decode: ALU core mode bits, low-nibble carry and flag sources.
module sm83_alu_op_decode
  import sm83_alu_ctrl_pkg::*;
(
  input  op_e   op_i,
  input  logic  cf_i,
  output logic  negate_o,
  output logic  carry_low_o,
  output rsv_t  rsv_o,
  output logic  n_o,
  output fsel_e h_sel_o,
  output fsel_e c_sel_o
);

  always_comb begin
    negate_o    = 1'b0;
    carry_low_o = 1'b0;
    rsv_o       = '0;
    n_o         = 1'b0;
    h_sel_o     = FSEL_ZERO;
    c_sel_o     = FSEL_ZERO;
    case (op_i)
      OP_ADD: begin
        h_sel_o = FSEL_CARRY;
        c_sel_o = FSEL_CARRY;
      end
      OP_ADC: begin
        carry_low_o = cf_i;
        h_sel_o     = FSEL_CARRY;
        c_sel_o     = FSEL_CARRY;
      end
      OP_SUB, OP_CP: begin
        negate_o    = 1'b1;
        carry_low_o = 1'b1;
        n_o         = 1'b1;
        h_sel_o     = FSEL_INV;
        c_sel_o     = FSEL_INV;
      end
      OP_SBC: begin
        // Borrow-in enters the complement adder as an inverted carry.
        negate_o    = 1'b1;
        carry_low_o = ~cf_i;
        n_o         = 1'b1;
        h_sel_o     = FSEL_INV;
        c_sel_o     = FSEL_INV;
      end
      OP_AND: begin
        carry_low_o = 1'b1;
        rsv_o       = '{r: 1'b0, s: 1'b1, v: 1'b0};
        h_sel_o     = FSEL_ONE;
      end
      OP_XOR: rsv_o = '{r: 1'b1, s: 1'b0, v: 1'b0};
      OP_OR:  rsv_o = '{r: 1'b1, s: 1'b0, v: 1'b1};
      default: ;
    endcase
  end

endmodule

// File: rtl/sm83_alu_ctrl.sv
// Sequencer driving a nibble-serial SM83 ALU: loads operands, runs low then
// high nibble, strobes the result and registers Z/N/H/C.
module sm83_alu_ctrl
  import sm83_alu_ctrl_pkg::*;
#(
  parameter int unsigned ALU_WIDTH = 4
) (
  input logic             clk,
  input logic             reset,
  sm83_alu_ctrl_if.slave  bus
);
  localparam int unsigned DW = 2 * ALU_WIDTH;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          cf_q, cf_d;
  logic          hc_q, hc_d;
  logic          fc_q, fc_d;
  flags_t        flags_q, flags_d;

  logic  dec_negate;
  logic  dec_carry_low;
  rsv_t  dec_rsv;
  logic  dec_n;
  fsel_e dec_h_sel;
  fsel_e dec_c_sel;

  sm83_alu_op_decode u_decode (
    .op_i        (op_q),
    .cf_i        (cf_q),
    .negate_o    (dec_negate),
    .carry_low_o (dec_carry_low),
    .rsv_o       (dec_rsv),
    .n_o         (dec_n),
    .h_sel_o     (dec_h_sel),
    .c_sel_o     (dec_c_sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      cf_q    <= 1'b0;
      hc_q    <= 1'b0;
      fc_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cf_q    <= cf_d;
      hc_q    <= hc_d;
      fc_q    <= fc_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cf_d    = cf_q;
    hc_d    = hc_q;
    fc_d    = fc_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LOAD_A;
          op_d    = op_e'(bus.op);
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          cf_d    = bus.cf_in;
        end
      end
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: state_d = ST_LOW;
      ST_LOW: begin
        state_d = ST_HIGH;
        hc_d    = bus.alu_carry;
      end
      ST_HIGH: begin
        state_d = ST_RESULT;
        fc_d    = bus.alu_carry;
      end
      ST_RESULT: begin
        state_d   = ST_DONE;
        flags_d.z = bus.alu_zero;
        flags_d.n = dec_n;
        flags_d.h = flag_pick(dec_h_sel, hc_q);
        flags_d.c = flag_pick(dec_c_sel, fc_q);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.alu_din      = '0;
    bus.load_a       = 1'b0;
    bus.load_b       = 1'b0;
    bus.shift_oe     = 1'b0;
    bus.result_oe    = 1'b0;
    bus.op_low       = 1'b0;
    bus.op_b_high    = 1'b0;
    bus.negate       = 1'b0;
    bus.carry_in     = 1'b0;
    bus.no_carry_out = 1'b0;
    bus.force_carry  = 1'b0;
    bus.ignore_carry = 1'b0;
    bus.result_we    = 1'b0;
    case (state_q)
      ST_LOAD_A: begin
        bus.alu_din  = a_q;
        bus.shift_oe = 1'b1;
        bus.load_a   = 1'b1;
      end
      ST_LOAD_B: begin
        bus.alu_din  = b_q;
        bus.shift_oe = 1'b1;
        bus.load_b   = 1'b1;
      end
      ST_LOW, ST_HIGH, ST_RESULT: begin
        bus.negate       = dec_negate;
        bus.no_carry_out = dec_rsv.r;
        bus.force_carry  = dec_rsv.s;
        bus.ignore_carry = dec_rsv.v;
        bus.op_low       = (state_q == ST_LOW);
        bus.op_b_high    = (state_q != ST_LOW);
        bus.carry_in     = (state_q == ST_LOW) ? dec_carry_low : hc_q;
        bus.result_oe    = (state_q == ST_RESULT);
        bus.result_we    = (state_q == ST_RESULT) && (op_q != OP_CP);
      end
      default: ;
    endcase
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.flag_z = flags_q.z;
  assign bus.flag_n = flags_q.n;
  assign bus.flag_h = flags_q.h;
  assign bus.flag_c = flags_q.c;

endmodule

// File: tb/tb_sm83_alu_ctrl.sv
// Self-checking bench: emulates a nibble-serial ALU from the control outputs
// and compares results/flags against plain 8-bit arithmetic.
module tb_sm83_alu_ctrl;
  import sm83_alu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sm83_alu_ctrl_if #(.ALU_WIDTH(4)) bus ();

  sm83_alu_ctrl #(.ALU_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ALU emulation: operand latches on negedge, nibble results stored on negedge.
  logic [7:0] alu_a = '0;
  logic [7:0] alu_b = '0;
  logic [3:0] alu_lo = '0;
  logic [3:0] alu_hi = '0;
  logic [3:0] nib_a, nib_b, nib_r;
  logic       nib_co;

  always_comb begin
    logic [4:0] s;
    nib_a = bus.op_low ? alu_a[3:0] : alu_a[7:4];
    nib_b = bus.op_low ? alu_b[3:0] : alu_b[7:4];
    if (bus.negate) nib_b = ~nib_b;
    s = 5'd0;
    case ({bus.no_carry_out, bus.force_carry, bus.ignore_carry})
      3'b000:  s = {1'b0, nib_a} + {1'b0, nib_b} + {4'd0, bus.carry_in};
      3'b010:  s = {1'b0, nib_a & nib_b};
      3'b100:  s = {1'b0, nib_a ^ nib_b};
      3'b101:  s = {1'b0, nib_a | nib_b};
      default: s = 5'd0;
    endcase
    nib_r  = s[3:0];
    nib_co = s[4];
  end

  assign bus.alu_carry = (bus.op_low || bus.op_b_high) ? nib_co : 1'b0;
  assign bus.alu_zero  = ({alu_hi, alu_lo} == 8'h00);

  always @(negedge clk) begin
    if (bus.shift_oe && bus.load_a) alu_a <= bus.alu_din;
    if (bus.shift_oe && bus.load_b) alu_b <= bus.alu_din;
    if (bus.op_low) alu_lo <= nib_r;
    if (bus.op_b_high && !bus.result_oe) alu_hi <= nib_r;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: flags packed {z,n,h,c}.
  task automatic ref_op(input int op, input int a, input int b, input int cf,
                        output int res, output logic [3:0] fl);
    int s;
    logic n, h, c;
    s = 0; n = 1'b0; h = 1'b0; c = 1'b0;
    case (op)
      0: begin s = a + b;      h = ((a & 15) + (b & 15)) > 15;      c = s > 255; end
      1: begin s = a + b + cf; h = ((a & 15) + (b & 15) + cf) > 15; c = s > 255; end
      2, 7: begin s = a - b;   h = (a & 15) < (b & 15);             c = a < b;  n = 1'b1; end
      3: begin s = a - b - cf; h = (a & 15) < ((b & 15) + cf);      c = a < (b + cf); n = 1'b1; end
      4: begin s = a & b; h = 1'b1; end
      5: s = a ^ b;
      default: s = a | b;
    endcase
    res = s & 255;
    fl  = {res == 0, n, h, c};
  endtask

  function automatic logic [10:0] ctrl_vec();
    return {bus.load_a, bus.load_b, bus.shift_oe, bus.result_oe, bus.op_low,
            bus.op_b_high, bus.negate, bus.carry_in, bus.no_carry_out,
            bus.force_carry, bus.ignore_carry};
  endfunction

  function automatic logic [3:0] flags_out();
    return {bus.flag_z, bus.flag_n, bus.flag_h, bus.flag_c};
  endfunction

  task automatic run_op(input int op, input int a, input int b, input int cf, input bit poke);
    int         res, we_cnt, done_cnt, done_k;
    logic [3:0] fl;
    logic [7:0] we_val;
    ref_op(op, a, b, cf, res, fl);
    we_cnt = 0; done_cnt = 0; done_k = 0; we_val = '0;
    bus.op = op[2:0]; bus.a_in = a[7:0]; bus.b_in = b[7:0]; bus.cf_in = cf[0];
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 1) begin
        check("load_a_din", bus.alu_din, a & 255);
        check("load_a_ctl", {bus.load_a, bus.load_b, bus.shift_oe, bus.busy}, 4'b1011);
      end
      if (k == 2) check("load_b_din", bus.alu_din, b & 255);
      if (k == 3) check("low_ctl", {bus.op_low, bus.op_b_high, bus.negate}, {2'b10, fl[2]});
      if (k == 4) check("high_ctl", {bus.op_low, bus.op_b_high}, 2'b01);
      if (k == 3 && poke) bus.start = 1'b1;
      if (k == 4) bus.start = 1'b0;
      if (bus.result_we) begin we_cnt++; we_val = {alu_hi, alu_lo}; end
      if (bus.done) begin done_cnt++; done_k = k; end
      if (k == 6) begin
        check("done_flags", flags_out(), fl);
        check("done_ctl_zero", {ctrl_vec(), bus.alu_din}, 0);
        check("done_busy", bus.busy, 1);
      end
      if (k == 7) begin
        check("idle_busy", {bus.busy, bus.done, bus.result_we}, 0);
        check("flags_hold", flags_out(), fl);
      end
      if (k < 7) begin @(posedge clk); #1; end
    end
    check("result_we_count", we_cnt, (op == 7) ? 0 : 1);
    if (op != 7) check("result_value", we_val, res);
    check("done_count", done_cnt, 1);
    check("done_latency", done_k, 6);
  endtask

  initial begin
    int dcnt, wcnt;
    bus.start = 1'b0; bus.op = '0; bus.a_in = '0; bus.b_in = '0; bus.cf_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {bus.busy, bus.done, bus.result_we, ctrl_vec(), bus.alu_din, flags_out()}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(0, 8'h3A, 8'hC6, 0, 1'b0);
    run_op(2, 8'h10, 8'h01, 0, 1'b0);
    run_op(3, 8'h00, 8'h00, 1, 1'b0);
    run_op(4, 8'hF0, 8'h3C, 0, 1'b0);
    run_op(6, 8'h0F, 8'hA0, 0, 1'b0);
    run_op(5, 8'hFF, 8'hFF, 0, 1'b0);
    run_op(7, 8'h42, 8'h42, 0, 1'b0);
    run_op(1, 8'h0F, 8'h00, 1, 1'b1);

    // Held start: second operation begins on the first IDLE edge after DONE.
    bus.op = 3'd0; bus.a_in = 8'h11; bus.b_in = 8'h22; bus.cf_in = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    check("held_done", bus.done, 1);
    @(posedge clk); #1;
    check("held_idle_gap", bus.busy, 0);
    @(posedge clk); #1;
    check("held_restart", {bus.load_a, bus.busy}, 2'b11);
    bus.start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("held_drained", bus.busy, 0);

    // Abort during HIGH.
    run_op(0, 8'hFF, 8'h01, 0, 1'b0);
    bus.op = 3'd2; bus.a_in = 8'h55; bus.b_in = 8'h66; bus.cf_in = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_in_high", bus.op_b_high, 1);
    reset = 1'b1;
    #1;
    check("abort_outputs", {bus.busy, bus.done, bus.result_we, ctrl_vec(), bus.alu_din, flags_out()}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    dcnt = 0; wcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
      if (bus.result_we) wcnt++;
    end
    check("abort_no_done", {dcnt, wcnt}, 0);
    check("abort_idle", bus.busy, 0);

    for (int i = 0; i < 40; i++)
      run_op($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 1), 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sm83_alu_ctrl.md
SM83_ALU_CTRL -- requirements
Module: sm83_alu_ctrl

Interface
REQ-001 Parameter ALU_WIDTH, default 4, the ALU nibble width; data width is 2*ALU_WIDTH (8).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request an operation; accepted only when busy=0.
REQ-005 op  in  3  operation: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP.
REQ-006 a_in, b_in  in  8  operands, sampled on the accepting edge.
REQ-007 cf_in  in  1  incoming carry flag, used by ADC/SBC, sampled with operands.
REQ-008 alu_din  out  8  operand bus to ALU din.
REQ-009 load_a, load_b, shift_oe, result_oe, op_low, op_b_high, negate  out  1 each  ALU controls.
REQ-010 carry_in, no_carry_out, force_carry, ignore_carry  out  1 each  ALU core controls (R, S, V).
REQ-011 alu_carry, alu_zero  in  1 each  ALU carry and zero outputs.
REQ-012 busy  out  1  high from the cycle after acceptance through the DONE cycle.
REQ-013 result_we  out  1  one-cycle strobe: ALU dout holds a valid result; never asserted for CP.
REQ-014 done  out  1  one-cycle pulse; flag outputs are valid.
REQ-015 flag_z, flag_n, flag_h, flag_c  out  1 each  registered result flags.

Function
REQ-016 The FSM SHALL step IDLE -> LOAD_A -> LOAD_B -> LOW -> HIGH -> RESULT -> DONE -> IDLE, one cycle per state with no stalls; done occurs 6 cycles after the accepting edge.
REQ-017 In IDLE, start=1 SHALL latch op, a_in, b_in and cf_in at the edge; in any other state start is ignored.
REQ-018 LOAD_A SHALL drive alu_din=latched A, shift_oe=1, load_a=1; LOAD_B SHALL drive alu_din=latched B, shift_oe=1, load_b=1; the ALU captures these on the mid-cycle negedge.
REQ-019 LOW SHALL drive op_low=1 and op_b_high=0; HIGH and RESULT SHALL drive op_low=0 and op_b_high=1.
REQ-020 negate=1 in LOW, HIGH and RESULT for SUB, SBC and CP; otherwise 0.
REQ-021 LOW carry_in: ADD 0, ADC cf, SUB 1, SBC !cf, CP 1, AND 1, XOR 0, OR 0.
REQ-022 At the end of LOW the block SHALL register alu_carry as half-carry hc; HIGH and RESULT SHALL drive carry_in=hc.
REQ-023 (R,S,V): arithmetic ops (0,0,0); AND (0,1,0); XOR (1,0,0); OR (1,0,1); these are held constant from LOW through RESULT.
REQ-024 At the end of HIGH the block SHALL register alu_carry as full carry fc.
REQ-025 RESULT SHALL drive result_oe=1 and result_we=1 (except CP); flags SHALL register at the end of RESULT.
REQ-026 Flags: Z=alu_zero; N=1 for SUB/SBC/CP, else 0; H=hc (ADD/ADC), !hc (SUB/SBC/CP), 1 (AND), 0 (XOR/OR); C=fc (ADD/ADC), !fc (SUB/SBC/CP), 0 (logic).
REQ-027 In IDLE and DONE all ALU control outputs SHALL be 0 and alu_din SHALL be 0.
REQ-028 Flags SHALL hold their value until the next RESULT state completes.
REQ-029 start held high continuously SHALL start a new operation on the first IDLE edge after DONE, with no back-to-back overlap.

Reset
REQ-030 While reset=1, the FSM SHALL be IDLE; busy, done and result_we SHALL be 0; all flags, hc, fc, latched operands and ALU controls SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL abort immediately; no result_we or done is produced for the aborted operation.

Structure
REQ-032 Package sm83_alu_ctrl_pkg SHALL hold the op enum, the FSM state enum and a packed flags struct {z,n,h,c}.
REQ-033 Combinational sub-module sm83_alu_op_decode SHALL map op and cf to negate, carry_in for LOW, R/S/V, N and the H/C selection; the FSM instantiates it once.

Verification
REQ-034 ADD 0x3A+0xC6 -> result 0x00, Z=1 N=0 H=1 C=1, done 6 cycles after start.
REQ-035 SUB 0x10-0x01 -> 0x0F, Z=0 N=1 H=1 C=0; SBC 0x00-0x00 with cf=1 -> 0xFF, N=1 H=1 C=1.
REQ-036 AND 0xF0&0x3C -> 0x30, H=1 C=0; OR 0x0F|0xA0 -> 0xAF; XOR 0xFF^0xFF -> 0x00, Z=1.
REQ-037 CP 0x42 vs 0x42 -> Z=1 N=1 C=0; result_we never asserted.
REQ-038 Reset asserted during HIGH -> next cycle IDLE and all outputs 0, no done; start pulsed while busy -> ignored, exactly one done.
